// File: rtl/mmu_addr_trans.sv
// mmu_addr_trans: single-stage virtual-to-physical address translation.
// A request is resolved through direct-address mode, one of two direct-mapped
// windows, or a TLB search. The result is returned one cycle after accept.
// Valid/ready handshakes are used on the request and response sides.
module mmu_addr_trans (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_va,
    input  logic [1:0]  req_type,
    input  logic [1:0]  req_plv,
    input  logic        csr_da,
    input  logic [1:0]  csr_datm,
    input  logic [9:0]  csr_asid,
    input  logic [31:0] csr_dmw0,
    input  logic [31:0] csr_dmw1,
    output logic        tlb_fetch,
    output logic [18:0] tlb_vppn,
    output logic        tlb_odd_page,
    output logic [9:0]  tlb_asid,
    input  logic        tlb_found,
    input  logic        tlb_v,
    input  logic        tlb_d,
    input  logic [5:0]  tlb_ps,
    input  logic [19:0] tlb_ppn,
    input  logic [1:0]  tlb_mat,
    input  logic [1:0]  tlb_plv,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_pa,
    output logic [1:0]  rsp_mat,
    output logic        rsp_excp,
    output logic [5:0]  rsp_ecode,
    output logic [31:0] rsp_badv
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_DA  = 2'd0,
        MODE_DMW = 2'd1,
        MODE_TLB = 2'd2
    } mode_t;

    localparam logic [1:0] TYPE_FETCH = 2'd0;
    localparam logic [1:0] TYPE_STORE = 2'd2;

    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_PME  = 6'h04;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] stg_va;
    logic [1:0]  stg_type;
    logic [1:0]  stg_plv;
    mode_t       stg_mode;
    logic [31:0] stg_pa;
    logic [1:0]  stg_mat;

    logic        accept;
    logic        dmw0_hit;
    logic        dmw1_hit;
    mode_t       req_mode;
    logic [31:0] req_direct_pa;
    logic [1:0]  req_direct_mat;

    logic        stg_is_store;
    logic        stg_is_fetch;
    logic [31:0] tlb_pa;

    logic        unused_dmw_bits;

    // A window hits only for PLV0 or PLV3 with the matching enable bit set.
    function automatic logic window_hit(input logic [31:0] win,
                                        input logic [31:0] va,
                                        input logic [1:0]  plv);
        logic plv_ok;
        plv_ok = ((plv == 2'd0) && win[0]) || ((plv == 2'd3) && win[3]);
        return (va[31:29] == win[31:29]) && plv_ok;
    endfunction

    assign unused_dmw_bits = ^{csr_dmw0[28], csr_dmw0[24:6], csr_dmw0[2:1],
                               csr_dmw1[28], csr_dmw1[24:6], csr_dmw1[2:1]};

    // A new request may enter whenever the stage is empty or draining, never during flush.
    assign req_ready = !flush && ((state_q == ST_EMPTY) || rsp_ready);
    assign accept    = req_valid && req_ready;

    assign dmw0_hit  = window_hit(csr_dmw0, req_va, req_plv);
    assign dmw1_hit  = window_hit(csr_dmw1, req_va, req_plv);

    assign tlb_vppn     = req_va[31:13];
    assign tlb_odd_page = req_va[12];
    assign tlb_asid     = csr_asid;
    assign tlb_fetch    = accept && (req_mode == MODE_TLB);

    // Resolve the translation mode at accept time; direct modes also produce PA/MAT here.
    always_comb begin
        req_mode       = MODE_TLB;
        req_direct_pa  = 32'h0;
        req_direct_mat = 2'd0;
        if (csr_da) begin
            req_mode       = MODE_DA;
            req_direct_pa  = req_va;
            req_direct_mat = csr_datm;
        end else if (dmw0_hit) begin
            req_mode       = MODE_DMW;
            req_direct_pa  = {csr_dmw0[27:25], req_va[28:0]};
            req_direct_mat = csr_dmw0[5:4];
        end else if (dmw1_hit) begin
            req_mode       = MODE_DMW;
            req_direct_pa  = {csr_dmw1[27:25], req_va[28:0]};
            req_direct_mat = csr_dmw1[5:4];
        end
    end

    // Stage occupancy: flush empties it, accept fills it, consume alone drains it.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request so later CSR changes cannot disturb the in-flight translation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_va   <= 32'h0;
            stg_type <= 2'd0;
            stg_plv  <= 2'd0;
            stg_mode <= MODE_DA;
            stg_pa   <= 32'h0;
            stg_mat  <= 2'd0;
        end else if (accept) begin
            stg_va   <= req_va;
            stg_type <= req_type;
            stg_plv  <= req_plv;
            stg_mode <= req_mode;
            stg_pa   <= req_direct_pa;
            stg_mat  <= req_direct_mat;
        end
    end

    assign stg_is_store = (stg_type == TYPE_STORE);
    assign stg_is_fetch = (stg_type == TYPE_FETCH);
    assign tlb_pa = (tlb_ps == 6'd12) ? {tlb_ppn, stg_va[11:0]}
                                      : {tlb_ppn[19:9], stg_va[20:0]};

    // Build the response; TLB results are held stable by the TLB while the stage is full.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_pa    = 32'h0;
        rsp_mat   = 2'd0;
        rsp_excp  = 1'b0;
        rsp_ecode = 6'h0;
        rsp_badv  = 32'h0;
        if (state_q == ST_FULL) begin
            rsp_valid = 1'b1;
            rsp_badv  = stg_va;
            if (stg_mode == MODE_TLB) begin
                if (!tlb_found) begin
                    rsp_excp  = 1'b1;
                    rsp_ecode = ECODE_TLBR;
                end else if (!tlb_v) begin
                    rsp_excp  = 1'b1;
                    rsp_ecode = stg_is_fetch ? ECODE_PIF :
                                stg_is_store ? ECODE_PIS : ECODE_PIL;
                end else if (stg_plv > tlb_plv) begin
                    rsp_excp  = 1'b1;
                    rsp_ecode = ECODE_PPI;
                end else if (stg_is_store && !tlb_d) begin
                    rsp_excp  = 1'b1;
                    rsp_ecode = ECODE_PME;
                end else begin
                    rsp_pa  = tlb_pa;
                    rsp_mat = tlb_mat;
                end
            end else begin
                rsp_pa  = stg_pa;
                rsp_mat = stg_mat;
            end
        end
    end

endmodule

// File: tb/tb_mmu_addr_trans.sv
// tb_mmu_addr_trans: directed bench for mmu_addr_trans with a queue-based
// reference model, a registered TLB stand-in and literal spot checks.
module tb_mmu_addr_trans;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_va = 32'h0;
    logic [1:0]  req_type = 2'd0;
    logic [1:0]  req_plv = 2'd0;
    logic        csr_da = 1'b0;
    logic [1:0]  csr_datm = 2'd0;
    logic [9:0]  csr_asid = 10'h15;
    logic [31:0] csr_dmw0 = 32'h0;
    logic [31:0] csr_dmw1 = 32'h0;
    logic        tlb_fetch;
    logic [18:0] tlb_vppn;
    logic        tlb_odd_page;
    logic [9:0]  tlb_asid;
    logic        tlb_found = 1'b0;
    logic        tlb_v = 1'b0;
    logic        tlb_d = 1'b0;
    logic [5:0]  tlb_ps = 6'd12;
    logic [19:0] tlb_ppn = 20'h0;
    logic [1:0]  tlb_mat = 2'd0;
    logic [1:0]  tlb_plv = 2'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_pa;
    logic [1:0]  rsp_mat;
    logic        rsp_excp;
    logic [5:0]  rsp_ecode;
    logic [31:0] rsp_badv;

    // Answer the TLB will give on its next search.
    logic        prog_found = 1'b0;
    logic        prog_v = 1'b0;
    logic        prog_d = 1'b0;
    logic [5:0]  prog_ps = 6'd12;
    logic [19:0] prog_ppn = 20'h0;
    logic [1:0]  prog_mat = 2'd0;
    logic [1:0]  prog_plv = 2'd0;

    typedef struct {
        logic [31:0] pa;
        logic [1:0]  mat;
        logic        excp;
        logic [5:0]  ecode;
        logic [31:0] badv;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   fetch_cnt = 0;
    int   deliver_cnt = 0;

    mmu_addr_trans dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va),
        .req_type(req_type), .req_plv(req_plv),
        .csr_da(csr_da), .csr_datm(csr_datm), .csr_asid(csr_asid),
        .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
        .tlb_fetch(tlb_fetch), .tlb_vppn(tlb_vppn), .tlb_odd_page(tlb_odd_page),
        .tlb_asid(tlb_asid), .tlb_found(tlb_found), .tlb_v(tlb_v), .tlb_d(tlb_d),
        .tlb_ps(tlb_ps), .tlb_ppn(tlb_ppn), .tlb_mat(tlb_mat), .tlb_plv(tlb_plv),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pa(rsp_pa),
        .rsp_mat(rsp_mat), .rsp_excp(rsp_excp), .rsp_ecode(rsp_ecode),
        .rsp_badv(rsp_badv)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit window_hits(input logic [31:0] win, input logic [31:0] va,
                                       input logic [1:0] plv);
        bit en;
        en = (plv == 2'd0) ? win[0] : (plv == 2'd3) ? win[3] : 1'b0;
        return ((va >> 29) == (win >> 29)) && en;
    endfunction

    // What the translation of this request must produce, from the current CSRs and TLB answer.
    function automatic rsp_t model(input logic [31:0] va, input logic [1:0] typ,
                                   input logic [1:0] plv, output bit via_tlb);
        rsp_t r;
        int   code;
        r.pa = 32'h0; r.mat = 2'd0; r.excp = 1'b0; r.ecode = 6'h0; r.badv = va;
        via_tlb = 1'b0;
        if (csr_da) begin
            r.pa = va; r.mat = csr_datm;
            return r;
        end
        if (window_hits(csr_dmw0, va, plv)) begin
            r.pa  = ((csr_dmw0 >> 25) << 29) | (va & 32'h1FFF_FFFF);
            r.mat = 2'((csr_dmw0 >> 4) & 32'h3);
            return r;
        end
        if (window_hits(csr_dmw1, va, plv)) begin
            r.pa  = ((csr_dmw1 >> 25) << 29) | (va & 32'h1FFF_FFFF);
            r.mat = 2'((csr_dmw1 >> 4) & 32'h3);
            return r;
        end
        via_tlb = 1'b1;
        code = -1;
        if (!prog_found)                     code = 63;
        else if (!prog_v)                    code = (typ == 2'd0) ? 3 : (typ == 2'd2) ? 2 : 1;
        else if (plv > prog_plv)             code = 7;
        else if (typ == 2'd2 && !prog_d)     code = 4;
        if (code >= 0) begin
            r.excp = 1'b1; r.ecode = 6'(code);
        end else begin
            if (prog_ps == 6'd12) r.pa = (32'(prog_ppn) << 12) | (va & 32'hFFF);
            else                  r.pa = ((32'(prog_ppn) >> 9) << 21) | (va & 32'h1F_FFFF);
            r.mat = prog_mat;
        end
        return r;
    endfunction

    // Registered TLB stand-in: results change only on a search strobe.
    always @(posedge clk) begin
        if (tlb_fetch) begin
            tlb_found <= prog_found; tlb_v <= prog_v; tlb_d <= prog_d;
            tlb_ps <= prog_ps; tlb_ppn <= prog_ppn; tlb_mat <= prog_mat; tlb_plv <= prog_plv;
        end
    end

    // Model update: the queue holds responses accepted but not yet consumed.
    always @(posedge clk or negedge rst_n) begin
        bit   via_tlb;
        bit   acc;
        rsp_t r;
        if (!rst_n) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else begin
            acc = req_valid && (exp_q.size() == 0 || rsp_ready);
            r = model(req_va, req_type, req_plv, via_tlb);
            if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(r);
        end
    end

    // Event counters for strobes and delivered responses.
    always @(posedge clk) begin
        if (rst_n) begin
            if (tlb_fetch) fetch_cnt++;
            if (rsp_valid && rsp_ready && !flush) deliver_cnt++;
        end
    end

    // Compare every cycle, mid-cycle, against the model.
    always @(negedge clk) begin
        bit   via_tlb;
        bit   exp_ready;
        rsp_t cur;
        exp_ready = !flush && (exp_q.size() == 0 || rsp_ready);
        cur = model(req_va, req_type, req_plv, via_tlb);
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        checkOutput("tlb_fetch", 32'(tlb_fetch), 32'(req_valid && exp_ready && via_tlb));
        checkOutput("tlb_vppn", 32'(tlb_vppn), req_va >> 13);
        checkOutput("tlb_odd", 32'(tlb_odd_page), (req_va >> 12) & 32'h1);
        checkOutput("tlb_asid", 32'(tlb_asid), 32'(csr_asid));
        if (exp_q.size() != 0) begin
            checkOutput("rsp_valid", 32'(rsp_valid), 32'h1);
            checkOutput("rsp_pa", rsp_pa, exp_q[0].pa);
            checkOutput("rsp_mat", 32'(rsp_mat), 32'(exp_q[0].mat));
            checkOutput("rsp_excp", 32'(rsp_excp), 32'(exp_q[0].excp));
            checkOutput("rsp_ecode", 32'(rsp_ecode), 32'(exp_q[0].ecode));
            checkOutput("rsp_badv", rsp_badv, exp_q[0].badv);
        end else begin
            checkOutput("idle_valid", 32'(rsp_valid), 32'h0);
            checkOutput("idle_pa", rsp_pa, 32'h0);
            checkOutput("idle_attr", {24'h0, rsp_mat, rsp_excp, rsp_ecode[4:0]}, 32'h0);
            checkOutput("idle_ecode", 32'(rsp_ecode), 32'h0);
            checkOutput("idle_badv", rsp_badv, 32'h0);
        end
    end

    // Present one request and hold it until accepted; leaves req_valid high.
    task automatic applyStimulus(input logic [31:0] va, input logic [1:0] typ,
                                 input logic [1:0] plv);
        bit acc;
        req_va = va; req_type = typ; req_plv = plv; req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) checkOutput("accept_timeout", 32'(acc), 32'h1);
    endtask

    task automatic setTlb(input bit found, input bit v, input bit d, input logic [5:0] ps,
                          input logic [19:0] ppn, input logic [1:0] mat, input logic [1:0] plv);
        prog_found = found; prog_v = v; prog_d = d; prog_ps = ps;
        prog_ppn = ppn; prog_mat = mat; prog_plv = plv;
    endtask

    task automatic expectRsp(input string name, input logic [31:0] pa, input logic [1:0] mat,
                             input bit excp, input logic [5:0] ecode, input logic [31:0] va);
        checkOutput({name, "_valid"}, 32'(rsp_valid), 32'h1);
        checkOutput({name, "_pa"}, rsp_pa, pa);
        checkOutput({name, "_mat"}, 32'(rsp_mat), 32'(mat));
        checkOutput({name, "_excp"}, 32'(rsp_excp), 32'(excp));
        checkOutput({name, "_ecode"}, 32'(rsp_ecode), 32'(ecode));
        checkOutput({name, "_badv"}, rsp_badv, va);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One request, check the response in the cycle after accept, then let it drain.
    task automatic oneShot(input string name, input logic [31:0] va, input logic [1:0] typ,
                           input logic [1:0] plv, input logic [31:0] pa, input logic [1:0] mat,
                           input bit excp, input logic [5:0] ecode, input int fetches);
        int f0;
        f0 = fetch_cnt;
        applyStimulus(va, typ, plv);
        req_valid = 1'b0;
        expectRsp(name, pa, mat, excp, ecode, va);
        checkOutput({name, "_fetches"}, 32'(fetch_cnt - f0), 32'(fetches));
        idleCycles(1);
    endtask

    initial begin
        int f0;
        int d0;
        #1 rst_n = 1'b0;
        idleCycles(3);
        checkOutput("reset_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_pa", rsp_pa, 32'h0);
        checkOutput("reset_badv", rsp_badv, 32'h0);
        checkOutput("reset_fetch", 32'(tlb_fetch), 32'h0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // Direct-address mode; CSRs change right after accept to prove capture.
        csr_da = 1'b1; csr_datm = 2'd1;
        f0 = fetch_cnt;
        applyStimulus(32'h1C00_0123, 2'd1, 2'd0);
        req_valid = 1'b0;
        csr_da = 1'b0; csr_datm = 2'd3;
        expectRsp("da", 32'h1C00_0123, 2'd1, 1'b0, 6'h0, 32'h1C00_0123);
        checkOutput("da_fetches", 32'(fetch_cnt - f0), 32'h0);
        idleCycles(1);

        // Direct-mapped windows.
        csr_dmw0 = 32'hA000_0011;
        csr_dmw1 = 32'h8E00_0029;
        oneShot("dmw0", 32'hA123_4567, 2'd1, 2'd0, 32'h0123_4567, 2'd1, 1'b0, 6'h0, 0);
        oneShot("dmw1", 32'h8000_1000, 2'd0, 2'd3, 32'hE000_1000, 2'd2, 1'b0, 6'h0, 0);
        setTlb(1, 1, 1, 6'd12, 20'h00ABC, 2'd2, 2'd3);
        oneShot("dmw0_plv3", 32'hA123_4567, 2'd1, 2'd3, 32'h00AB_C567, 2'd2, 1'b0, 6'h0, 1);
        csr_dmw0 = 32'hA000_0019;
        oneShot("dmw_plv1", 32'hA000_0040, 2'd1, 2'd1, 32'h00AB_C040, 2'd2, 1'b0, 6'h0, 1);

        // TLB translations.
        csr_dmw0 = 32'h0; csr_dmw1 = 32'h0;
        setTlb(1, 1, 1, 6'd12, 20'h12345, 2'd1, 2'd3);
        oneShot("tlb4k", 32'h0040_1ABC, 2'd1, 2'd3, 32'h1234_5ABC, 2'd1, 1'b0, 6'h0, 1);
        setTlb(1, 1, 1, 6'd21, 20'h00400, 2'd1, 2'd3);
        oneShot("tlb2m", 32'h0054_3210, 2'd1, 2'd3, 32'h0054_3210, 2'd1, 1'b0, 6'h0, 1);

        // Exceptions, in priority order.
        setTlb(0, 0, 0, 6'd12, 20'h12345, 2'd1, 2'd0);
        oneShot("tlbr", 32'h0000_1000, 2'd1, 2'd3, 32'h0, 2'd0, 1'b1, 6'h3F, 1);
        setTlb(1, 0, 1, 6'd12, 20'h12345, 2'd1, 2'd0);
        oneShot("pis", 32'h0000_2004, 2'd2, 2'd3, 32'h0, 2'd0, 1'b1, 6'h02, 1);
        oneShot("pif", 32'h0000_2008, 2'd0, 2'd0, 32'h0, 2'd0, 1'b1, 6'h03, 1);
        oneShot("pil_t3", 32'h0000_200C, 2'd3, 2'd0, 32'h0, 2'd0, 1'b1, 6'h01, 1);
        setTlb(1, 1, 1, 6'd12, 20'h12345, 2'd1, 2'd0);
        oneShot("ppi", 32'h0000_3000, 2'd1, 2'd3, 32'h0, 2'd0, 1'b1, 6'h07, 1);
        setTlb(1, 1, 0, 6'd12, 20'h12345, 2'd1, 2'd3);
        oneShot("pme", 32'h0000_4000, 2'd2, 2'd0, 32'h0, 2'd0, 1'b1, 6'h04, 1);

        // Back-to-back with a one-cycle response stall.
        csr_dmw0 = 32'hA000_0011;
        f0 = fetch_cnt; d0 = deliver_cnt;
        fork
            begin
                setTlb(1, 1, 1, 6'd12, 20'h11111, 2'd1, 2'd3);
                applyStimulus(32'h0040_1ABC, 2'd1, 2'd3);
                applyStimulus(32'hA000_0100, 2'd1, 2'd0);
                setTlb(1, 1, 1, 6'd12, 20'h22222, 2'd2, 2'd3);
                applyStimulus(32'h0040_2DEF, 2'd2, 2'd0);
                req_valid = 1'b0;
            end
            begin
                rsp_ready = 1'b1;
                @(posedge clk); #1 rsp_ready = 1'b0;
                @(posedge clk); #1 rsp_ready = 1'b1;
            end
        join
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput("b2b_drain", 32'(exp_q.size()), 32'h0);
        checkOutput("b2b_delivered", 32'(deliver_cnt - d0), 32'h3);
        checkOutput("b2b_fetches", 32'(fetch_cnt - f0), 32'h2);

        // Flush while full, with a competing request that must not be taken.
        rsp_ready = 1'b0;
        setTlb(1, 1, 1, 6'd12, 20'h33333, 2'd1, 2'd3);
        applyStimulus(32'h0040_3000, 2'd1, 2'd0);
        req_valid = 1'b0;
        idleCycles(1);
        f0 = fetch_cnt; d0 = deliver_cnt;
        flush = 1'b1; rsp_ready = 1'b1;
        req_valid = 1'b1; req_va = 32'h0040_5000;
        idleCycles(1);
        flush = 1'b0; req_valid = 1'b0;
        checkOutput("flush_valid", 32'(rsp_valid), 32'h0);
        checkOutput("flush_delivered", 32'(deliver_cnt - d0), 32'h0);
        checkOutput("flush_fetches", 32'(fetch_cnt - f0), 32'h0);
        idleCycles(2);

        // Reset in the middle of a held translation.
        rsp_ready = 1'b0;
        applyStimulus(32'hA000_0200, 2'd1, 2'd0);
        req_valid = 1'b0;
        #3 rst_n = 1'b0;
        idleCycles(1);
        rst_n = 1'b1; rsp_ready = 1'b1;
        d0 = deliver_cnt;
        idleCycles(3);
        checkOutput("rst_mid_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_mid_delivered", 32'(deliver_cnt - d0), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
